// File: rtl/hermes_inject_arbiter_pkg.sv
// Shared types and constants for the Hermes local-port injection arbiter.
// Packet layout: header flit, size flit, then size payload flits.
package hermes_inject_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HEADER,
        ARB_SIZE,
        ARB_PAYLOAD
    } arb_state_t;

    localparam int HDR_FLIT  = 0;
    localparam int SIZE_FLIT = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last wins.
// Search order is last+1, last+2, ... wrapping modulo N.
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         valid
);

    logic [W-1:0] cand;

    // Walk the order backwards so the earliest candidate is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = N; i >= 1; i--) begin
            cand = W'((int'(last) + i) % N);
            if (req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hermes_inject_arbiter.sv
// Packet-level round-robin sharing of one Hermes local port between sources.
// The owner keeps the port until its whole packet has crossed.
module hermes_inject_arbiter
    import hermes_inject_arbiter_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int FLIT_SIZE = 32,
    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_SRC-1:0]                    src_rx_i,
    output logic [N_SRC-1:0]                    src_credit_o,
    input  logic [N_SRC-1:0][FLIT_SIZE-1:0]     src_data_i,
    output logic                                noc_tx_o,
    input  logic                                noc_credit_i,
    output logic [FLIT_SIZE-1:0]                noc_data_o,
    output logic [GW-1:0]                       grant_o,
    output logic                                busy_o
);

    arb_state_t           state;
    logic [FLIT_SIZE-1:0] cnt;
    logic [GW-1:0]        grant;
    logic [GW-1:0]        last;
    logic [GW-1:0]        arb_winner;
    logic                 arb_valid;
    logic                 xfer;

    rr_arbiter #(.N(N_SRC)) u_rr (
        .req    (src_rx_i),
        .last   (last),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Data path is a pure mux so flits cross with no added latency.
    always_comb begin
        noc_tx_o     = 1'b0;
        noc_data_o   = '0;
        src_credit_o = '0;
        if (state != ARB_IDLE) begin
            noc_tx_o            = src_rx_i[grant];
            noc_data_o          = src_data_i[grant];
            src_credit_o[grant] = noc_credit_i;
        end
    end

    assign xfer    = noc_tx_o && noc_credit_i;
    assign busy_o  = (state != ARB_IDLE);
    assign grant_o = grant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ARB_IDLE;
            cnt   <= '0;
            grant <= '0;
            last  <= GW'(N_SRC - 1);
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (arb_valid) begin
                        grant <= arb_winner;
                        last  <= arb_winner;
                        state <= ARB_HEADER;
                    end
                end
                ARB_HEADER: begin
                    if (xfer) state <= ARB_SIZE;
                end
                ARB_SIZE: begin
                    if (xfer) begin
                        cnt   <= noc_data_o;
                        state <= (noc_data_o != '0) ? ARB_PAYLOAD : ARB_IDLE;
                    end
                end
                ARB_PAYLOAD: begin
                    if (xfer) begin
                        cnt <= cnt - FLIT_SIZE'(1);
                        if (cnt == FLIT_SIZE'(1)) state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hermes_inject_arbiter.sv
// Directed bench for hermes_inject_arbiter with a flit scoreboard.
// Three sources; expected flits are queued in the order they must appear.
module tb_hermes_inject_arbiter;
    import hermes_inject_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int FS = 32;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         src_rx;
    logic [N-1:0]         src_credit;
    logic [N-1:0][FS-1:0] src_data;
    logic                 noc_tx;
    logic                 noc_credit;
    logic [FS-1:0]        noc_data;
    logic [1:0]           grant;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int x0;

    logic [FS-1:0] sq [N][$];
    int            exp_src [$];
    logic [FS-1:0] exp_dat [$];

    hermes_inject_arbiter #(.N_SRC(N), .FLIT_SIZE(FS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .src_rx_i     (src_rx),
        .src_credit_o (src_credit),
        .src_data_i   (src_data),
        .noc_tx_o     (noc_tx),
        .noc_credit_i (noc_credit),
        .noc_data_o   (noc_data),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [FS-1:0] obs, logic [FS-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            src_rx[s]   = (sq[s].size() > 0);
            src_data[s] = (sq[s].size() > 0) ? sq[s][0] : '0;
        end
    endtask

    task automatic load(int s, logic [FS-1:0] hdr, int size, logic [FS-1:0] base);
        logic [FS-1:0] f [2];
        f[HDR_FLIT]  = hdr;
        f[SIZE_FLIT] = FS'(size);
        for (int k = 0; k < 2 + size; k++) begin
            logic [FS-1:0] v;
            v = (k < 2) ? f[k] : base + FS'(k - 2);
            sq[s].push_back(v);
            exp_src.push_back(s);
            exp_dat.push_back(v);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] fire;
        @(negedge clk);
        if (noc_tx && noc_credit) begin
            xfers++;
            checks++;
            assert (exp_dat.size() != 0) else begin
                errors++;
                $error("FAIL spurious_flit observed %0h expected none", noc_data);
            end
            if (exp_dat.size() != 0) begin
                chk("flit_src", FS'(grant), FS'(exp_src.pop_front()));
                chk("flit_data", noc_data, exp_dat.pop_front());
            end
        end
        fire = src_rx & src_credit;
        @(posedge clk);
        #1;
        for (int s = 0; s < N; s++)
            if (fire[s] && sq[s].size() > 0) void'(sq[s].pop_front());
        drive();
    endtask

    task automatic run_until_empty(string tag, int max);
        int n = 0;
        drive();
        while ((exp_dat.size() != 0 || busy) && n < max) begin
            cycle();
            n++;
        end
        checks++;
        assert (n < max) else begin
            errors++;
            $error("FAIL %s_timeout observed %0d cycles expected < %0d", tag, n, max);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int s = 0; s < N; s++) sq[s].delete();
        exp_src.delete();
        exp_dat.delete();
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        noc_credit = 1'b1;
        drive();
        #3;
        chk("rst_busy", FS'(busy), 0);
        chk("rst_tx", FS'(noc_tx), 0);
        chk("rst_data", noc_data, 0);
        chk("rst_credit", FS'(src_credit), 0);
        chk("rst_grant", FS'(grant), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single packet: one idle cycle then five consecutive flits
        x0 = xfers;
        load(0, 32'h0102, 3, 32'hA);
        drive();
        repeat (6) cycle();
        chk("single_busy", FS'(busy), 0);
        chk("single_count", FS'(xfers - x0), 5);
        chk("single_drained", FS'(exp_dat.size()), 0);

        // contention: src0, src1, then src0 again
        do_reset();
        x0 = xfers;
        load(0, 32'h10, 1, 32'h100);
        load(1, 32'h11, 0, 32'h0);
        load(0, 32'h12, 1, 32'h200);
        drive();
        repeat (11) cycle();
        chk("cont_busy", FS'(busy), 0);
        chk("cont_count", FS'(xfers - x0), 8);
        chk("cont_drained", FS'(exp_dat.size()), 0);

        // credit stall during payload of four
        x0 = xfers;
        load(0, 32'h20, 4, 32'h300);
        drive();
        repeat (4) cycle();
        noc_credit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_credit", FS'(src_credit[0]), 0);
            chk("stall_busy", FS'(busy), 1);
        end
        chk("stall_frozen", FS'(xfers - x0), 3);
        noc_credit = 1'b1;
        repeat (3) cycle();
        chk("stall_busy_end", FS'(busy), 0);
        chk("stall_count", FS'(xfers - x0), 6);

        // zero payload
        x0 = xfers;
        load(1, 32'h30, 0, 32'h0);
        drive();
        repeat (2) cycle();
        chk("zero_busy_mid", FS'(busy), 1);
        cycle();
        chk("zero_busy_end", FS'(busy), 0);
        chk("zero_count", FS'(xfers - x0), 2);

        // fairness: grants must go 0,1,2,0,1,2
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++)
                load(s, FS'(32'h40 + 4 * r + s), 1, FS'(32'h400 + 16 * s + r));
        run_until_empty("fair", 60);
        chk("fair_drained", FS'(exp_dat.size()), 0);

        // reset in the middle of a seven-flit packet
        do_reset();
        load(1, 32'h50, 5, 32'h500);
        drive();
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", FS'(busy), 0);
        chk("mid_rst_tx", FS'(noc_tx), 0);
        chk("mid_rst_credit", FS'(src_credit), 0);
        chk("mid_rst_data", noc_data, 0);
        chk("mid_rst_grant", FS'(grant), 0);
        do_reset();
        load(0, 32'h60, 0, 32'h0);
        load(2, 32'h62, 0, 32'h0);
        run_until_empty("post_rst", 30);
        chk("post_rst_drained", FS'(exp_dat.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
